// File: rtl/wavegen_pkg.sv
// Constants and FSM encoding shared by the waveform generator blocks
// (sweep controller, tuning-word generator, DDS core).
package wavegen_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int FREQ_W = 20;
  localparam int FTW_W  = 32;
  localparam int MULT_W = 16;
  localparam int SHIFT  = 10;
  localparam int PROD_W = FREQ_W + MULT_W;

  // round(2^32 / CLK_HZ * 2^SHIFT)
  localparam logic [MULT_W-1:0] MULT      = 16'd43980;
  localparam logic [FTW_W-1:0]  RESET_FTW = 32'd4294921;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } ftw_state_e;

  // The product never exceeds PROD_W bits, so bits above it read as zero.
  function automatic logic [FTW_W-1:0] ftw_from_product(input logic [PROD_W-1:0] p);
    return FTW_W'(p >> SHIFT);
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Serial shift-add multiplier: one bit of the constant multiplier per cycle,
// done is high during the last add cycle, product is valid the cycle after.
module shift_add_mult #(
  parameter int                OP_W     = 20,
  parameter int                MULT_W   = 16,
  parameter logic [MULT_W-1:0] MULT_VAL = 16'd1,
  parameter int                PROD_W   = OP_W + MULT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   operand,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  localparam int              CNT_W    = $clog2(MULT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PROD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic [PROD_W-1:0] partial_s;

  // Next-state for the accumulator, bit index and run flag
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    partial_s = PROD_W'(operand) << cnt_q;
    if (start) begin
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (MULT_VAL[cnt_q]) begin
        acc_d = acc_q + partial_s;
      end else begin
        acc_d = acc_q;
      end
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        run_d = 1'b0;
      end else begin
        run_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done    = run_q && (cnt_q == CNT_LAST);
  assign product = acc_q;

endmodule

// File: rtl/freq_tuning_word_gen.sv
// Converts the sweep frequency (Hz) into the DDS tuning word; the published
// word only changes, atomically, at the end of a serial conversion.
module freq_tuning_word_gen
  import wavegen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FREQ_W-1:0] freq_in,
  output logic [FTW_W-1:0]  ftw,
  output logic              ftw_valid,
  output logic              busy
);

  ftw_state_e        state_q, state_d;
  logic [FREQ_W-1:0] freq_op_q, freq_op_d;
  logic              pend_q, pend_d;
  logic [FTW_W-1:0]  ftw_q, ftw_d;
  logic              ftw_valid_q, ftw_valid_d;
  logic              busy_q, busy_d;
  logic              mult_start_s;
  logic              mult_done_s;
  logic [PROD_W-1:0] product_s;

  shift_add_mult #(
    .OP_W     (FREQ_W),
    .MULT_W   (MULT_W),
    .MULT_VAL (MULT),
    .PROD_W   (PROD_W)
  ) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mult_start_s),
    .operand (freq_op_q),
    .done    (mult_done_s),
    .product (product_s)
  );

  // Change detection, conversion sequencing and output update
  always_comb begin
    state_d      = state_q;
    freq_op_d    = freq_op_q;
    pend_d       = pend_q;
    ftw_d        = ftw_q;
    ftw_valid_d  = 1'b0;
    mult_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        // pend forces one conversion after reset even if freq_in equals 0
        if (pend_q || (freq_in != freq_op_q)) begin
          freq_op_d    = freq_in;
          pend_d       = 1'b0;
          mult_start_s = 1'b1;
          state_d      = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (mult_done_s) begin
          state_d = DONE;
        end else begin
          state_d = MUL;
        end
      end
      DONE: begin
        ftw_d       = ftw_from_product(product_s);
        ftw_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      freq_op_q   <= '0;
      pend_q      <= 1'b1;
      ftw_q       <= RESET_FTW;
      ftw_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_op_q   <= freq_op_d;
      pend_q      <= pend_d;
      ftw_q       <= ftw_d;
      ftw_valid_q <= ftw_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign ftw       = ftw_q;
  assign ftw_valid = ftw_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_freq_tuning_word_gen.sv
// Self-checking bench for freq_tuning_word_gen against an arithmetic model
// of ftw = floor(freq * 43980 / 1024).
module tb_freq_tuning_word_gen;

  logic        clk;
  logic        rst_n;
  logic [19:0] freq_in;
  logic [31:0] ftw;
  logic        ftw_valid;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  int glitch_cnt = 0;
  logic [31:0] prev_ftw;
  logic        prev_rst_n = 1'b0;

  freq_tuning_word_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .freq_in   (freq_in),
    .ftw       (ftw),
    .ftw_valid (ftw_valid),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_ftw(input int unsigned f);
    longint unsigned p;
    p = longint'(f) * 64'd43980;
    return 32'(p / 64'd1024);
  endfunction

  // Count pulses and catch any ftw change that is not accompanied by ftw_valid
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ftw_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    if (rst_n === 1'b1 && prev_rst_n === 1'b1 && ftw_valid !== 1'b1 && ftw !== prev_ftw)
      glitch_cnt <= glitch_cnt + 1;
    prev_ftw   <= ftw;
    prev_rst_n <= rst_n;
  end

  task automatic wait_valid(input int budget, output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_n++;
    end while (ftw_valid !== 1'b1 && lat < budget);
    if (ftw_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    int lat, bn, p0;
    rst_n = 1'b0;
    freq_in = 20'd100000;
    repeat (3) @(negedge clk);
    n_tests++; if (ftw !== 32'd4294921) begin n_fail++; $display("FAIL reset_ftw: got %0d want %0d", ftw, 32'd4294921); end
    n_tests++; if (ftw_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ftw_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    p0 = pulse_cnt;
    rst_n = 1'b1;
    wait_valid(40, lat, bn);
    n_tests++; if (lat !== 18) begin n_fail++; $display("FAIL reset_first_latency: got %0d want 18", lat); end
    n_tests++; if (ftw !== model_ftw(100000)) begin n_fail++; $display("FAIL reset_first_ftw: got %0d want %0d", ftw, model_ftw(100000)); end
    repeat (30) @(negedge clk);
    n_tests++; if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL reset_pulse_count: got %0d want 1", pulse_cnt - p0); end
  endtask

  task automatic test_step();
    int lat, bn, p0;
    p0 = pulse_cnt;
    freq_in = 20'd1000;
    wait_valid(40, lat, bn);
    n_tests++; if (lat !== 18) begin n_fail++; $display("FAIL step_latency: got %0d want 18", lat); end
    n_tests++; if (bn !== 17) begin n_fail++; $display("FAIL step_busy_cycles: got %0d want 17", bn); end
    n_tests++; if (ftw !== 32'd42949) begin n_fail++; $display("FAIL step_ftw: got %0d want 42949", ftw); end
    @(negedge clk);
    n_tests++; if (ftw_valid !== 1'b0) begin n_fail++; $display("FAIL step_pulse_width: got %b want 0", ftw_valid); end
    repeat (60) @(negedge clk);
    n_tests++; if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL step_held_pulses: got %0d want 1", pulse_cnt - p0); end
  endtask

  task automatic test_values();
    int unsigned vals [2] = '{999000, 0};
    int lat, bn;
    foreach (vals[i]) begin
      freq_in = 20'(vals[i]);
      wait_valid(40, lat, bn);
      n_tests++; if (lat !== 18) begin n_fail++; $display("FAIL value_latency f=%0d: got %0d want 18", vals[i], lat); end
      n_tests++; if (ftw !== model_ftw(vals[i])) begin n_fail++; $display("FAIL value_ftw f=%0d: got %0d want %0d", vals[i], ftw, model_ftw(vals[i])); end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn, p0;
    p0 = pulse_cnt;
    freq_in = 20'd1000;
    @(negedge clk);
    freq_in = 20'd500000;
    @(negedge clk);
    freq_in = 20'd999000;
    wait_valid(40, lat, bn);
    n_tests++; if (lat <= 0 || ftw !== model_ftw(1000)) begin n_fail++; $display("FAIL b2b_first_ftw: got %0d (lat %0d) want %0d", ftw, lat, model_ftw(1000)); end
    wait_valid(40, lat, bn);
    n_tests++; if (lat !== 18) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 18", lat); end
    n_tests++; if (ftw !== model_ftw(999000)) begin n_fail++; $display("FAIL b2b_second_ftw: got %0d want %0d", ftw, model_ftw(999000)); end
    repeat (40) @(negedge clk);
    n_tests++; if (pulse_cnt - p0 !== 2) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d want 2", pulse_cnt - p0); end
  endtask

  task automatic test_reset_mid();
    int lat, bn, p0;
    freq_in = 20'd1000;
    wait_valid(40, lat, bn);
    repeat (3) @(negedge clk);
    freq_in = 20'd999000;
    repeat (9) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    p0 = pulse_cnt;
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if (ftw !== 32'd4294921) begin n_fail++; $display("FAIL midrst_ftw: got %0d want 4294921", ftw); end
    n_tests++; if (busy !== 1'b0 || ftw_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got busy=%b valid=%b want 0 0", busy, ftw_valid); end
    repeat (4) @(negedge clk);
    n_tests++; if (pulse_cnt - p0 !== 0) begin n_fail++; $display("FAIL midrst_spurious: got %0d pulses want 0", pulse_cnt - p0); end
    rst_n = 1'b1;
    wait_valid(40, lat, bn);
    n_tests++; if (lat !== 18) begin n_fail++; $display("FAIL midrst_latency: got %0d want 18", lat); end
    n_tests++; if (ftw !== model_ftw(999000)) begin n_fail++; $display("FAIL midrst_ftw_after: got %0d want %0d", ftw, model_ftw(999000)); end
    repeat (30) @(negedge clk);
    n_tests++; if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL midrst_pulse_count: got %0d want 1", pulse_cnt - p0); end
  endtask

  task automatic test_random();
    int unsigned f, cur;
    int lat, bn, p0;
    cur = 999000;
    for (int k = 0; k < 8; k++) begin
      f = $urandom_range(999000, 1000);
      if (f == cur) f = (f == 999000) ? 1000 : f + 1;
      cur = f;
      p0 = pulse_cnt;
      freq_in = 20'(f);
      wait_valid(40, lat, bn);
      n_tests++; if (lat !== 18) begin n_fail++; $display("FAIL rand_latency f=%0d: got %0d want 18", f, lat); end
      n_tests++; if (ftw !== model_ftw(f)) begin n_fail++; $display("FAIL rand_ftw f=%0d: got %0d want %0d", f, ftw, model_ftw(f)); end
      repeat (100 - 18) @(negedge clk);
      n_tests++; if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL rand_pulses f=%0d: got %0d want 1", f, pulse_cnt - p0); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    freq_in = 20'd0;
    test_reset();
    test_step();
    test_values();
    test_back_to_back();
    test_reset_mid();
    test_random();
    n_tests++; if (glitch_cnt !== 0) begin n_fail++; $display("FAIL ftw_stable: got %0d unflagged changes want 0", glitch_cnt); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
